// File: rtl/uart_tx_fifo_drain.sv
// UART transmit serializer draining a show-ahead TX fifo: start, DBIT data bits LSB-first,
// optional parity (define UART_TX_PARITY_EN), then SB_TICK/16 stop bits, timed by a 16x s_tick.
module uart_tx_fifo_drain #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_rdata,
`ifdef UART_TX_PARITY_EN
  input  logic            parity_odd,
`endif
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick,
  output logic [2:0]      state_dbg
);

  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_LAST    = SW'(15);
  localparam logic [SW-1:0] STOP_LAST = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t          state;
  logic [SW-1:0]   s_reg;
  logic [NW-1:0]   n_reg;
  logic [DBIT-1:0] b_reg;
  logic [DBIT-1:0] b_shift;
  logic            tx_reg;
  logic            done_reg;
`ifdef UART_TX_PARITY_EN
  logic            par_reg;
`endif

  // Pop handshake: fifo_rd is high exactly while IDLE and the fifo is non-empty; the
  // head word (fifo_rdata) is captured on the same rising edge, so each pop is one clk.
  assign fifo_rd      = reset && (state == IDLE) && !fifo_empty;
  assign tx_busy      = (state != IDLE);
  assign tx           = tx_reg;
  assign tx_done_tick = done_reg;
  assign state_dbg    = state;
  assign b_shift      = b_reg >> 1;

  // tx_reg is loaded with the line value of the state being entered, so tx never glitches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tx_reg   <= 1'b1;
      b_reg    <= '0;
      s_reg    <= '0;
      n_reg    <= '0;
      done_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_reg  <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          tx_reg <= 1'b1;
          if (!fifo_empty) begin
            state  <= START;
            b_reg  <= fifo_rdata;
            s_reg  <= '0;
            tx_reg <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_reg <= (^fifo_rdata) ^ parity_odd;
`endif
          end
        end
        START: begin
          if (s_tick) begin
            if (s_reg == S_LAST) begin
              state  <= DATA;
              s_reg  <= '0;
              n_reg  <= '0;
              tx_reg <= b_reg[0];
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s_reg == S_LAST) begin
              b_reg <= b_shift;
              s_reg <= '0;
              if (n_reg == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                state  <= PARITY;
                tx_reg <= par_reg;
`else
                state  <= STOP;
                tx_reg <= 1'b1;
`endif
              end else begin
                n_reg  <= n_reg + 1'b1;
                tx_reg <= b_shift[0];
              end
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s_reg == S_LAST) begin
              state  <= STOP;
              s_reg  <= '0;
              tx_reg <= 1'b1;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s_reg == STOP_LAST) begin
              state    <= IDLE;
              s_reg    <= '0;
              done_reg <= 1'b1;
              tx_reg   <= 1'b1;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          tx_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Self-checking bench for uart_tx_fifo_drain: fifo model, serial-line monitor with
// an expected-frame queue, plus a second instance with SB_TICK=32.
module tb_uart_tx_fifo_drain;
  localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NPB = 1;
`else
  localparam int NPB = 0;
`endif
  localparam int NBITS   = 1 + DBIT + NPB;
  localparam int FRAME   = 16 * NBITS + 16;
  localparam int FRAME32 = 16 * NBITS + 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_tick = 1'b0;
  logic fifo_empty = 1'b1;
  logic [DBIT-1:0] fifo_rdata = '0;
  logic fifo_rd, tx, tx_busy, tx_done_tick;
  logic [2:0] state_dbg;
  logic fifo_empty32 = 1'b1;
  logic [DBIT-1:0] fifo_rdata32 = '0;
  logic fifo_rd32, tx32, tx_busy32, tx_done_tick32;
  logic [2:0] state_dbg32;
`ifdef UART_TX_PARITY_EN
  logic parity_odd = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  logic [DBIT:0] exp_q[$];
  logic [DBIT-1:0] fifo_q[$];
  int tick_mode = 0;
  int tick_div = 0;
  int cyc = 0;

  uart_tx_fifo_drain #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick), .state_dbg(state_dbg)
  );

  uart_tx_fifo_drain #(.DBIT(DBIT), .SB_TICK(32)) dut32 (
    .clk(clk), .reset(reset), .s_tick(s_tick),
    .fifo_empty(fifo_empty32), .fifo_rdata(fifo_rdata32),
`ifdef UART_TX_PARITY_EN
    .parity_odd(parity_odd),
`endif
    .fifo_rd(fifo_rd32), .tx(tx32), .tx_busy(tx_busy32),
    .tx_done_tick(tx_done_tick32), .state_dbg(state_dbg32)
  );

  // clock / reset / baud tick
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    tick_div = (tick_div + 1) % 4;
    s_tick = (tick_mode == 1) ? 1'b1 : (tick_div == 0);
  end

  // show-ahead fifo model
  always @(posedge clk) begin
    if (fifo_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
    fifo_rdata <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // serial-line monitor and scoreboard
  int mon_cnt = 0;
  int mon_frames = 0;
  int mon_pops = 0;
  int last_done_cyc = -1000;
  int last_gap = 0;
  int bit_idx = 0;
  logic mon_in_frame = 1'b0;
  logic [DBIT:0] mon_word = '0;
  logic [DBIT:0] mon_last_word = '0;
  logic [DBIT:0] exp_w;

  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      mon_in_frame = 1'b0;
    end else begin
      if (fifo_rd) begin
        mon_pops++;
        checks++;
        if (fifo_empty !== 1'b0 || tx_busy !== 1'b0) begin
          failures++;
          $display("FAIL pop_protocol: fifo_empty=%0b tx_busy=%0b during fifo_rd, required 0/0", fifo_empty, tx_busy);
        end
      end
      if (!mon_in_frame) begin
        if (tx_done_tick) begin
          failures++;
          $display("FAIL stray_done: tx_done_tick=1 outside a frame, required 0");
        end
        if (tx === 1'b0) begin
          mon_in_frame = 1'b1;
          mon_cnt = 0;
          mon_word = '0;
          last_gap = cyc - last_done_cyc;
        end
      end
      if (mon_in_frame) begin
        if (tx_done_tick) begin
          checks++;
          if (mon_cnt != FRAME) begin
            failures++;
            $display("FAIL done_timing: done after %0d ticks, required %0d", mon_cnt, FRAME);
          end
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL frame_data: unexpected frame %h, required none", mon_word);
          end else begin
            exp_w = exp_q.pop_front();
            if (mon_word !== exp_w) begin
              failures++;
              $display("FAIL frame_data: got %h required %h", mon_word, exp_w);
            end
          end
          mon_frames++;
          mon_last_word = mon_word;
          last_done_cyc = cyc;
          mon_in_frame = 1'b0;
        end else if (s_tick) begin
          if (mon_cnt % 16 == 8) begin
            bit_idx = mon_cnt / 16;
            if (bit_idx == 0) begin
              checks++;
              if (tx !== 1'b0 || tx_busy !== 1'b1) begin
                failures++;
                $display("FAIL start_bit: tx=%0b tx_busy=%0b, required 0/1", tx, tx_busy);
              end
            end else if (bit_idx <= DBIT + NPB) begin
              mon_word[bit_idx-1] = tx;
            end else begin
              checks++;
              if (tx !== 1'b1) begin
                failures++;
                $display("FAIL stop_bit: tx=%0b required 1", tx);
              end
            end
          end
          mon_cnt++;
          if (mon_cnt > FRAME) begin
            failures++;
            $display("FAIL frame_overrun: %0d ticks without tx_done_tick, required %0d", mon_cnt, FRAME);
            mon_in_frame = 1'b0;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic push_word(input logic [DBIT-1:0] w);
    logic par;
`ifdef UART_TX_PARITY_EN
    par = (^w) ^ parity_odd;
`else
    par = 1'b0;
`endif
    fifo_q.push_back(w);
    exp_q.push_back({par, w});
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || mon_in_frame) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= max_cyc) begin
      failures++;
      $display("FAIL %s_drain: timeout with %0d frames pending, required 0", name, exp_q.size());
      exp_q.delete();
      fifo_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0 || fifo_rd !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: tx=%0b busy=%0b done=%0b rd=%0b, required 1/0/0/0",
               tx, tx_busy, tx_done_tick, fifo_rd);
    end
    checks++;
    if (tx32 !== 1'b1 || tx_busy32 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state32: tx=%0b busy=%0b, required 1/0", tx32, tx_busy32);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int p0 = mon_pops;
    int f0 = mon_frames;
    @(negedge clk);
    push_word(8'h55);
    wait_drain("single_55", 2000);
    checks++;
    if (mon_pops - p0 != 1) begin
      failures++;
      $display("FAIL single_pops: %0d pops, required 1", mon_pops - p0);
    end
    checks++;
    if (mon_frames - f0 != 1 || mon_last_word[DBIT-1:0] !== 8'h55) begin
      failures++;
      $display("FAIL single_frame: %0d frames last=%h, required 1 frame of 55", mon_frames - f0, mon_last_word[DBIT-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int p0 = mon_pops;
    int f0 = mon_frames;
    @(negedge clk);
    push_word(8'hA5);
    push_word(8'h3C);
    wait_drain("b2b", 4000);
    checks++;
    if (mon_frames - f0 != 2 || mon_pops - p0 != 2) begin
      failures++;
      $display("FAIL b2b_count: frames=%0d pops=%0d, required 2/2", mon_frames - f0, mon_pops - p0);
    end
    checks++;
    if (last_gap > 1) begin
      failures++;
      $display("FAIL b2b_gap: %0d idle clk after stop bit, required <=1", last_gap);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    repeat (10000) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_quiet: %0d violating cycles, required 0", bad);
    end
  endtask

  task automatic test_tick_continuous();
    int f0 = mon_frames;
    @(negedge clk);
    tick_mode = 1;
    push_word(DBIT'($urandom_range(255, 0)));
    push_word(DBIT'($urandom_range(255, 0)));
    wait_drain("tick_cont", 1500);
    tick_mode = 0;
    checks++;
    if (mon_frames - f0 != 2) begin
      failures++;
      $display("FAIL tick_cont_count: %0d frames, required 2", mon_frames - f0);
    end
  endtask

  task automatic test_random();
    int f0 = mon_frames;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      push_word(DBIT'($urandom_range(255, 0)));
      repeat ($urandom_range(300, 0)) @(negedge clk);
    end
    wait_drain("random", 8000);
    checks++;
    if (mon_frames - f0 != 6) begin
      failures++;
      $display("FAIL random_count: %0d frames, required 6", mon_frames - f0);
    end
  endtask

  task automatic test_stop_2();
    int cnt = 0;
    int n = 0;
    int done_at = -1;
    int bad_stop = 0;
    int bad_data = 0;
    @(negedge clk);
    fifo_rdata32 = 8'h00;
    fifo_empty32 = 1'b0;
    #1;
    checks++;
    if (fifo_rd32 !== 1'b1) begin
      failures++;
      $display("FAIL sb32_pop: fifo_rd=%0b, required 1", fifo_rd32);
    end
    @(negedge clk);
    fifo_empty32 = 1'b1;
    while (done_at < 0 && n < 4000) begin
      if (tx_done_tick32) begin
        done_at = cnt;
      end else if (s_tick) begin
        if (cnt % 16 == 8) begin
          if (cnt < 16 * (1 + DBIT)) begin
            if (tx32 !== 1'b0) bad_data++;
          end else if (cnt >= 16 * NBITS) begin
            if (tx32 !== 1'b1) bad_stop++;
          end
        end
        cnt++;
      end
      n++;
      @(negedge clk);
    end
    checks++;
    if (done_at != FRAME32) begin
      failures++;
      $display("FAIL sb32_done: done at tick %0d, required %0d", done_at, FRAME32);
    end
    checks++;
    if (bad_data != 0 || bad_stop != 0) begin
      failures++;
      $display("FAIL sb32_line: bad data=%0d bad stop=%0d, required 0/0", bad_data, bad_stop);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    @(negedge clk);
    parity_odd = 1'b0;
    push_word(8'h07);
    wait_drain("par_even", 2000);
    checks++;
    if (mon_last_word[DBIT] !== 1'b1) begin
      failures++;
      $display("FAIL parity_even: parity bit %0b, required 1", mon_last_word[DBIT]);
    end
    @(negedge clk);
    parity_odd = 1'b1;
    push_word(8'h07);
    wait_drain("par_odd", 2000);
    checks++;
    if (mon_last_word[DBIT] !== 1'b0) begin
      failures++;
      $display("FAIL parity_odd: parity bit %0b, required 0", mon_last_word[DBIT]);
    end
    parity_odd = 1'b0;
  endtask
`endif

  task automatic test_reset_mid_frame();
    int n = 0;
    int bad = 0;
    int f0 = mon_frames;
    int p0;
    @(negedge clk);
    push_word(8'hFF);
    while (!(mon_in_frame && mon_cnt >= 16 * 4 + 6) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL rst_mid_start: frame never reached data bit 3, required start");
    end
    reset = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done_tick !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_abort: tx=%0b busy=%0b done=%0b, required 1/0/0", tx, tx_busy, tx_done_tick);
    end
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    reset = 1'b1;
    p0 = mon_pops;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || mon_frames != f0 || mon_pops != p0 || fifo_q.size() != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet: bad=%0d frames=%0d pops=%0d fifo=%0d, required 0/0/0/0",
               bad, mon_frames - f0, mon_pops - p0, fifo_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_idle();
    test_tick_continuous();
    test_random();
    test_stop_2();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected: %0d frames, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
